// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU core: opcodes, ALU selects, controller
// states and instruction field positions.
package cpu_pkg;

  // Opcodes, instruction bits [15:12]
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_BZ   = 4'h9;
  localparam logic [3:0] OP_BPOS = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_NOP0 = 4'hC;
  localparam logic [3:0] OP_NOP1 = 4'hD;
  localparam logic [3:0] OP_NOP2 = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // ALU selects; R-type opcodes map straight onto these
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_NOR = 4'h5;
  localparam logic [3:0] ALU_SHL = 4'h6;
  localparam logic [3:0] ALU_SHR = 4'h7;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_LOAD  = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  // Instruction field bit positions
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS_MSB  = 8;
  localparam int RS_LSB  = 6;
  localparam int RT_MSB  = 5;
  localparam int RT_LSB  = 3;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;
  localparam int JT_MSB  = 7;
  localparam int JT_LSB  = 0;

  // Sign-extend the 6-bit immediate to the 16-bit datapath width
  function automatic logic [15:0] sext6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decode: IR -> datapath controls plus
// branch/jump/halt indications for the sequencing FSM.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [3:0]  alu_sel,
  output logic        imm_sel,
  output logic        rf_write,
  output logic [15:0] imm_data,
  output logic [2:0]  rs_addr,
  output logic [2:0]  rt_addr,
  output logic [2:0]  rd_addr,
  output logic        br_zero,
  output logic        br_pos,
  output logic        jump,
  output logic        halt
);

  logic [3:0] op;

  assign op      = ir[OP_MSB:OP_LSB];
  assign rd_addr = ir[RD_MSB:RD_LSB];
  assign rs_addr = ir[RS_MSB:RS_LSB];
  assign rt_addr = ir[RT_MSB:RT_LSB];

  // Opcode decode; branches force a zero immediate so the flags reflect rs
  always_comb begin
    alu_sel  = ALU_ADD;
    imm_sel  = 1'b0;
    rf_write = 1'b0;
    imm_data = sext6(ir[IMM_MSB:IMM_LSB]);
    br_zero  = 1'b0;
    br_pos   = 1'b0;
    jump     = 1'b0;
    halt     = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SHL, OP_SHR: begin
        alu_sel  = {1'b0, op[2:0]};
        rf_write = 1'b1;
      end
      OP_ADDI: begin
        imm_sel  = 1'b1;
        rf_write = 1'b1;
      end
      OP_BZ: begin
        imm_sel  = 1'b1;
        imm_data = 16'h0000;
        br_zero  = 1'b1;
      end
      OP_BPOS: begin
        imm_sel  = 1'b1;
        imm_data = 16'h0000;
        br_pos   = 1'b1;
      end
      OP_JMP:  jump = 1'b1;
      OP_HALT: halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU controller: owns PC and IR, fetches from a synchronous
// ROM and sequences each instruction through FETCH -> LOAD -> EXEC.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_FETCH | instr_addr = PC presented to the ROM
//   S_LOAD  | ROM data latched into IR, PC advanced by one
//   S_EXEC  | decode outputs live; write/flags/branch resolve on exit edge
//   S_HALT  | controls parked at reset values until reset
module control_unit
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clock,
  input  logic            reset,
  output logic [PC_W-1:0] instr_addr,
  input  logic [15:0]     instr_data,
  input  logic            zero_flag,
  input  logic            pos_flag,
  output logic            rf_write,
  output logic [2:0]      rs_addr,
  output logic [2:0]      rt_addr,
  output logic [2:0]      rd_addr,
  output logic [15:0]     imm_data,
  output logic            imm_sel,
  output logic [3:0]      alu_sel,
  output logic            mem_write,
  output logic            halted
);

  state_t          state, state_next;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;

  logic [3:0]  dec_alu_sel;
  logic        dec_imm_sel;
  logic        dec_rf_write;
  logic [15:0] dec_imm_data;
  logic [2:0]  dec_rs, dec_rt, dec_rd;
  logic        dec_br_zero, dec_br_pos, dec_jump, dec_halt;

  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] jump_target;

  instr_decoder u_decoder (
    .ir       (ir),
    .alu_sel  (dec_alu_sel),
    .imm_sel  (dec_imm_sel),
    .rf_write (dec_rf_write),
    .imm_data (dec_imm_data),
    .rs_addr  (dec_rs),
    .rt_addr  (dec_rt),
    .rd_addr  (dec_rd),
    .br_zero  (dec_br_zero),
    .br_pos   (dec_br_pos),
    .jump     (dec_jump),
    .halt     (dec_halt)
  );

  // PC already points past the branch during EXEC, so the target is PC + offset
  assign branch_taken  = (dec_br_zero && zero_flag) || (dec_br_pos && pos_flag);
  assign branch_target = pc + PC_W'($signed(ir[IMM_MSB:IMM_LSB]));
  assign jump_target   = PC_W'(ir[JT_MSB:JT_LSB]);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_next;
  end

  // Next-state logic; HALT is sticky until reset
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: state_next = S_LOAD;
      S_LOAD:  state_next = S_EXEC;
      S_EXEC:  state_next = dec_halt ? S_HALT : S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  // Output logic; decode is exposed only in EXEC so HALT shows reset values
  always_comb begin
    rf_write = 1'b0;
    imm_sel  = 1'b0;
    alu_sel  = ALU_ADD;
    imm_data = 16'h0000;
    rs_addr  = 3'd0;
    rt_addr  = 3'd0;
    rd_addr  = 3'd0;
    halted   = (state == S_HALT);
    if (state == S_EXEC) begin
      rf_write = dec_rf_write;
      imm_sel  = dec_imm_sel;
      alu_sel  = dec_alu_sel;
      imm_data = dec_imm_data;
      rs_addr  = dec_rs;
      rt_addr  = dec_rt;
      rd_addr  = dec_rd;
    end
  end

  // PC and IR: latch the instruction in LOAD, redirect on taken branch/jump in EXEC
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc <= '0;
      ir <= 16'h0000;
    end else begin
      case (state)
        S_LOAD: begin
          ir <= instr_data;
          pc <= pc + 1'b1;
        end
        S_EXEC: begin
          if (dec_jump)          pc <= jump_target;
          else if (branch_taken) pc <= branch_target;
        end
        default: ;
      endcase
    end
  end

  assign instr_addr = pc;
  assign mem_write  = 1'b0;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-instruction vector table plus
// hand sequences for wrap, halt and mid-instruction reset.
module tb_control_unit;

  logic        clock;
  logic        reset;
  logic [7:0]  instr_addr;
  logic [15:0] instr_data;
  logic        zero_flag, pos_flag;
  logic        rf_write, imm_sel, mem_write, halted;
  logic [2:0]  rs_addr, rt_addr, rd_addr;
  logic [15:0] imm_data;
  logic [3:0]  alu_sel;

  logic [15:0] rom [256];

  int checks = 0;
  int errors = 0;

  control_unit #(.PC_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .zero_flag  (zero_flag),
    .pos_flag   (pos_flag),
    .rf_write   (rf_write),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rd_addr    (rd_addr),
    .imm_data   (imm_data),
    .imm_sel    (imm_sel),
    .alu_sel    (alu_sel),
    .mem_write  (mem_write),
    .halted     (halted)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // synchronous instruction ROM
  always @(posedge clock) instr_data <= rom[instr_addr];

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] instr;
    logic        zf;
    logic        pf;
    logic        rf;
    logic        isel;
    logic [3:0]  alu;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [15:0] imm;
    logic [7:0]  next;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fill_rom(input logic [15:0] val);
    for (int i = 0; i < 256; i++) rom[i] = val;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    fill_rom(16'hC000);
    if (v.addr != 8'h00) rom[0] = {8'hB0, v.addr};
    rom[v.addr] = v.instr;
    zero_flag = v.zf;
    pos_flag  = v.pf;
    do_reset();
    if (v.addr != 8'h00) repeat (3) @(posedge clock);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk($sformatf("v%0d rf_write", idx), 32'(rf_write), 32'(v.rf));
    chk($sformatf("v%0d imm_sel", idx),  32'(imm_sel),  32'(v.isel));
    chk($sformatf("v%0d alu_sel", idx),  32'(alu_sel),  32'(v.alu));
    chk($sformatf("v%0d rd_addr", idx),  32'(rd_addr),  32'(v.rd));
    chk($sformatf("v%0d rs_addr", idx),  32'(rs_addr),  32'(v.rs));
    chk($sformatf("v%0d rt_addr", idx),  32'(rt_addr),  32'(v.rt));
    chk($sformatf("v%0d imm_data", idx), 32'(imm_data), 32'(v.imm));
    @(negedge clock);
    chk($sformatf("v%0d next_addr", idx), 32'(instr_addr), 32'(v.next));
    chk($sformatf("v%0d rf_pulse_end", idx), 32'(rf_write), 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    zero_flag = 1'b0;
    pos_flag  = 1'b0;
    fill_rom(16'hC000);

    //          addr   instr     zf    pf    rf    isel  alu   rd    rs    rt    imm        next
    vecs[0]  = '{8'h00, 16'h8245, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 3'd1, 3'd1, 3'd0, 16'h0005, 8'h01};
    vecs[1]  = '{8'h00, 16'h1298, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 3'd1, 3'd2, 3'd3, 16'h0018, 8'h01};
    vecs[2]  = '{8'h00, 16'h87FF, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 3'd3, 3'd7, 3'd7, 16'hFFFF, 8'h01};
    vecs[3]  = '{8'h00, 16'h7E3A, 1'b0, 1'b0, 1'b1, 1'b0, 4'h7, 3'd7, 3'd0, 3'd7, 16'hFFFA, 8'h01};
    vecs[4]  = '{8'h04, 16'h90BE, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 3'd0, 3'd2, 3'd7, 16'h0000, 8'h03};
    vecs[5]  = '{8'h04, 16'h90BE, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 3'd0, 3'd2, 3'd7, 16'h0000, 8'h05};
    vecs[6]  = '{8'h04, 16'hA0BE, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 3'd0, 3'd2, 3'd7, 16'h0000, 8'h03};
    vecs[7]  = '{8'h04, 16'hA0BE, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 3'd0, 3'd2, 3'd7, 16'h0000, 8'h05};
    vecs[8]  = '{8'h00, 16'hB0FF, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 3'd3, 3'd7, 16'hFFFF, 8'hFF};
    vecs[9]  = '{8'h00, 16'hC123, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 3'd4, 3'd4, 16'hFFE3, 8'h01};
    vecs[10] = '{8'h00, 16'h903E, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 3'd0, 3'd0, 3'd7, 16'h0000, 8'hFF};
    vecs[11] = '{8'h04, 16'h901F, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 3'd0, 3'd0, 3'd3, 16'h0000, 8'h24};

    // reset state while reset is held
    repeat (2) @(negedge clock);
    chk("rst instr_addr", 32'(instr_addr), 32'd0);
    chk("rst rf_write",   32'(rf_write),   32'd0);
    chk("rst imm_sel",    32'(imm_sel),    32'd0);
    chk("rst alu_sel",    32'(alu_sel),    32'd0);
    chk("rst imm_data",   32'(imm_data),   32'd0);
    chk("rst addrs",      32'({rd_addr, rs_addr, rt_addr}), 32'd0);
    chk("rst mem_write",  32'(mem_write),  32'd0);
    chk("rst halted",     32'(halted),     32'd0);

    for (int i = 0; i < 12; i++) run_vec(i);

    // ADDI cycle-by-cycle: FETCH at 0, LOAD, EXEC with pulse, FETCH at 1
    fill_rom(16'hC000);
    rom[0] = 16'h8245;
    do_reset();
    @(negedge clock);
    chk("seq load rf_write", 32'(rf_write), 32'd0);
    chk("seq load imm_sel",  32'(imm_sel),  32'd0);
    @(negedge clock);
    chk("seq exec rf_write", 32'(rf_write), 32'd1);
    @(negedge clock);
    chk("seq fetch addr",    32'(instr_addr), 32'd1);
    chk("seq fetch rf_write", 32'(rf_write), 32'd0);

    // JMP to 0xFF, NOP there, fetch wraps to 0x00
    fill_rom(16'hC000);
    rom[0]   = 16'hB0FF;
    rom[255] = 16'hC000;
    do_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("wrap fetch ff", 32'(instr_addr), 32'hFF);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("wrap fetch 00", 32'(instr_addr), 32'h00);

    // HALT after one ADDI: halted rises leaving EXEC, PC frozen at 2
    fill_rom(16'hC000);
    rom[0] = 16'h8245;
    rom[1] = 16'hF000;
    do_reset();
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("halt exec halted", 32'(halted), 32'd0);
    @(negedge clock);
    for (int c = 0; c < 20; c++) begin
      chk("halt halted", 32'(halted), 32'd1);
      chk("halt addr",   32'(instr_addr), 32'd2);
      chk("halt ctrl",   32'({rf_write, imm_sel, alu_sel}), 32'd0);
      @(negedge clock);
    end
    reset = 1'b0;
    #1;
    chk("halt rst halted", 32'(halted), 32'd0);
    chk("halt rst addr",   32'(instr_addr), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("halt restart rf_write", 32'(rf_write), 32'd1);

    // reset during EXEC of ADDI aborts the write immediately
    fill_rom(16'hC000);
    rom[0] = 16'h8245;
    do_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("abort exec rf_write", 32'(rf_write), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort rf_write", 32'(rf_write), 32'd0);
    chk("abort addr",     32'(instr_addr), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort refetch addr", 32'(instr_addr), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("abort rerun rf_write", 32'(rf_write), 32'd1);
    chk("abort rerun rd_addr",  32'(rd_addr),  32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
